// File: rtl/serial_arith_defs.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings
// and the default operand width.
package serial_arith_defs;

   localparam int W_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sub_state_t;

endpackage

// File: rtl/serial_subtractor_8_bit_full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module full_subtractor (
   output logic d,
   output logic bout,
   input  logic x,
   input  logic y,
   input  logic bin
);

   logic w_xy;

   // Difference bit and borrow-out of one bit position.
   always_comb begin
      w_xy = x ^ y;
      d    = w_xy ^ bin;
      bout = (~x & y) | (~w_xy & bin);
   end

endmodule

// File: rtl/serial_subtractor_8_bit.sv
// Bit-serial subtractor: diff = (a - b) mod 2^W, one bit per clock, LSB first,
// through one full_subtractor cell. start/done handshake, result held.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output ovf.
module serial_subtractor_8_bit
   import serial_arith_defs::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow,
`ifdef SERIAL_SUB_OVERFLOW_EN
   output logic         ovf,
`endif
   output logic         busy,
   output logic         done
);

   localparam int CNT_W = $clog2(W);

   sub_state_t         r_state;
   sub_state_t         w_state_nxt;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_diff;
   logic               r_borrow;
   logic               r_bin;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_d;
   logic               w_bout;
   logic               w_last;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic               r_a_msb;
   logic               r_b_msb;
   logic               r_ovf;
`endif

   assign w_last = (r_cnt == CNT_W'(W - 1));

   full_subtractor u_cell (
      .d    (w_d),
      .bout (w_bout),
      .x    (r_a[0]),
      .y    (r_b[0]),
      .bin  (r_bin)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state: start only matters in IDLE; DONE lasts one cycle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (r_state)
         ST_SHIFT: busy = 1'b1;
         ST_DONE:  begin busy = 1'b1; done = 1'b1; end
         default:  ;
      endcase
   end

   // Datapath: capture on accepted start, then shift one bit per SHIFT edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_bin    <= 1'b0;
         r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            ST_IDLE: if (start) begin
               r_a      <= a;
               r_b      <= b;
               r_diff   <= '0;
               r_borrow <= 1'b0;
               r_bin    <= 1'b0;
               r_cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
               r_a_msb  <= a[W-1];
               r_b_msb  <= b[W-1];
               r_ovf    <= 1'b0;
`endif
            end
            ST_SHIFT: begin
               r_a    <= r_a >> 1;
               r_b    <= r_b >> 1;
               r_diff <= {w_d, r_diff[W-1:1]};
               r_bin  <= w_bout;
               if (w_last) begin
                  // Counter parks at zero so it never wraps mid-operation.
                  r_cnt    <= '0;
                  r_borrow <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // w_d is the result MSB on the final bit.
                  r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign diff   = r_diff;
   assign borrow = r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign ovf    = r_ovf;
`endif

endmodule
